// File: rtl/dcache_responder.sv
// Word-array data memory answering one LSU request at a time; mem_done pulses LATENCY cycles after accept.
// No backpressure: the request is taken only in IDLE with lsu_state==01, and inputs are ignored while busy.
module dcache_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  lsu_state,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [31:0] addr,
    input  logic        addr_valid,
    input  logic [31:0] write_data,
    input  logic        write_data_valid,
    output logic        mem_done,
    output logic [31:0] DCache_data,
    output logic        busy,
    output logic        access_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    oor_q, oor_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [15:0]             rd_cnt_q, rd_cnt_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic [31:0]             mem_q [DEPTH];

    logic accept;
    logic in_wr;
    logic in_oor;
    logic enter_resp;
    logic mem_we;
    logic unused_addr_lsb;

    // Only state 01 marks a fresh request; the LSU keeps the old one on the bus afterwards.
    assign accept  = (lsu_state == 2'b01) && addr_valid &&
                     (read_mem || (write_mem && write_data_valid));
    assign in_wr   = write_mem && write_data_valid;
    assign in_oor  = |addr[31:ADDR_WIDTH+2];
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        oor_d      = oor_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_wr_d = in_wr;
                    idx_d   = addr[ADDR_WIDTH+1:2];
                    wdata_d = write_data;
                    oor_d   = in_oor;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The *_d operand values are valid on the entering edge for both the direct and the WAIT path.
    always_comb begin
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        if (enter_resp) begin
            if (op_wr_d) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
                mem_we   = !oor_d;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
                rdata_d  = oor_d ? 32'd0 : mem_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            oor_q    <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            oor_q    <= oor_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign mem_done    = (state_q == RESP);
    assign access_err  = (state_q == RESP) && oor_q;
    assign busy        = (state_q != IDLE);
    assign DCache_data = rdata_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: one LATENCY=2 and one LATENCY=1 instance against an array-based reference model.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  lsu_state;
    logic        read_mem, write_mem, addr_valid, write_data_valid;
    logic [31:0] addr, write_data;
    bit          sel;

    logic [1:0]  lsu_a, lsu_b;
    logic        done_a, busy_a, err_a, done_b, busy_b, err_b;
    logic [31:0] data_a, data_b;
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;

    logic        m_done, m_busy, m_err;
    logic [31:0] m_data;
    logic [15:0] m_rdc, m_wrc;

    logic [31:0] model_mem [2][256];
    int unsigned model_rd [2];
    int unsigned model_wr [2];
    logic [31:0] model_last [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees lsu_state==01, so the other never accepts.
    assign lsu_a  = sel ? 2'b00 : lsu_state;
    assign lsu_b  = sel ? lsu_state : 2'b00;
    assign m_done = sel ? done_b : done_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_err  = sel ? err_b  : err_a;
    assign m_data = sel ? data_b : data_a;
    assign m_rdc  = sel ? rdc_b  : rdc_a;
    assign m_wrc  = sel ? wrc_b  : wrc_a;

    dcache_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .lsu_state(lsu_a), .read_mem(read_mem), .write_mem(write_mem),
        .addr(addr), .addr_valid(addr_valid), .write_data(write_data),
        .write_data_valid(write_data_valid), .mem_done(done_a), .DCache_data(data_a),
        .busy(busy_a), .access_err(err_a), .rd_count(rdc_a), .wr_count(wrc_a)
    );

    dcache_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .lsu_state(lsu_b), .read_mem(read_mem), .write_mem(write_mem),
        .addr(addr), .addr_valid(addr_valid), .write_data(write_data),
        .write_data_valid(write_data_valid), .mem_done(done_b), .DCache_data(data_b),
        .busy(busy_b), .access_err(err_b), .rd_count(rdc_b), .wr_count(wrc_b)
    );

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model_mem[s][i] = 32'd0;
            model_rd[s]   = 0;
            model_wr[s]   = 0;
            model_last[s] = 32'd0;
        end
    endtask

    task automatic drive_idle();
        lsu_state        = 2'b00;
        read_mem         = 1'b0;
        write_mem        = 1'b0;
        addr_valid       = 1'b0;
        write_data_valid = 1'b0;
        addr             = 32'd0;
        write_data       = 32'd0;
    endtask

    // One complete transaction on the selected instance; late>0 holds write_data_valid low first.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int late);
        int          lat;
        bit          oor;
        logic [7:0]  idx;
        logic [31:0] exp_data;
        lat = sel ? 1 : 2;
        idx = a[9:2];
        oor = (a[31:10] != 22'd0);
        if (w) begin
            if (!oor) model_mem[sel][idx] = d;
            model_wr[sel]++;
        end else begin
            model_last[sel] = oor ? 32'd0 : model_mem[sel][idx];
            model_rd[sel]++;
        end
        exp_data = model_last[sel];

        for (int k = 0; k < late; k++) begin
            lsu_state = 2'b01; addr_valid = 1'b1; addr = a;
            write_mem = 1'b1; read_mem = 1'b0; write_data_valid = 1'b0; write_data = d;
            @(posedge clk); #1;
            tests++;
            if (m_busy !== 1'b0) begin
                fails++;
                $display("FAIL wdv_low_no_accept: busy=%b required 0 (cycle %0d)", m_busy, k);
            end
        end

        lsu_state  = 2'b01;
        addr_valid = 1'b1;
        addr       = a;
        write_mem  = w;
        read_mem   = w ? 1'($urandom % 2) : 1'b1;
        write_data_valid = w ? 1'b1 : 1'($urandom % 2);
        write_data = w ? d : $urandom;

        for (int i = 1; i <= lat + 2; i++) begin
            @(posedge clk); #1;
            tests++;
            if (m_done !== (i == lat)) begin
                fails++;
                $display("FAIL mem_done_timing: cycle %0d mem_done=%b required %b", i, m_done, (i == lat));
            end
            tests++;
            if (m_busy !== (i <= lat)) begin
                fails++;
                $display("FAIL busy: cycle %0d busy=%b required %b", i, m_busy, (i <= lat));
            end
            if (i == lat) begin
                tests++;
                if (m_err !== oor) begin
                    fails++;
                    $display("FAIL access_err: got %b required %b addr=%h", m_err, oor, a);
                end
                tests++;
                if (m_data !== exp_data) begin
                    fails++;
                    $display("FAIL dcache_data: got %h required %h addr=%h w=%b", m_data, exp_data, a, w);
                end
                tests++;
                if (m_rdc !== 16'(model_rd[sel]) || m_wrc !== 16'(model_wr[sel])) begin
                    fails++;
                    $display("FAIL counters: rd=%0d wr=%0d required rd=%0d wr=%0d",
                             m_rdc, m_wrc, model_rd[sel], model_wr[sel]);
                end
            end
            if (i == lat + 2) begin
                tests++;
                if (m_data !== exp_data) begin
                    fails++;
                    $display("FAIL dcache_data_hold: got %h required %h", m_data, exp_data);
                end
            end
            lsu_state = (i == 1) ? 2'b10 : (i == 2) ? 2'b11 : 2'b00;
        end
        drive_idle();
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({m_done, m_busy, m_err, m_data, m_rdc, m_wrc} !== 67'd0) begin
            fails++;
            $display("FAIL %s: done=%b busy=%b err=%b data=%h rd=%0d wr=%0d required all 0",
                     name, m_done, m_busy, m_err, m_data, m_rdc, m_wrc);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        sel = 1'b0; #1; check_all_zero("reset_lat2");
        sel = 1'b1; #1; check_all_zero("reset_lat1");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("after_reset_lat1");
        sel = 1'b0; #1;
        check_all_zero("after_reset_lat2");
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        access(1'b1, 32'h0000_0010, 32'h0000_00AB, 0);
        access(1'b0, 32'h0000_0010, 32'd0, 0);
    endtask

    task automatic test_stale();
        sel = 1'b0;
        access(1'b0, 32'h0000_0010, 32'd0, 0);
        read_mem = 1'b1; addr_valid = 1'b1; addr = 32'h0000_0010;
        for (int i = 0; i < 6; i++) begin
            lsu_state = (i % 3 == 0) ? 2'b10 : (i % 3 == 1) ? 2'b11 : 2'b00;
            @(posedge clk); #1;
            tests++;
            if (m_done !== 1'b0 || m_busy !== 1'b0 || m_rdc !== 16'(model_rd[0])) begin
                fails++;
                $display("FAIL stale_reaccept: done=%b busy=%b rd=%0d required 0 0 %0d",
                         m_done, m_busy, m_rdc, model_rd[0]);
            end
        end
        drive_idle();
    endtask

    task automatic test_wdv_late();
        sel = 1'b0;
        access(1'b1, 32'h0000_0044, 32'hCAFE_0001, 3);
        access(1'b0, 32'h0000_0044, 32'd0, 0);
    endtask

    task automatic test_out_of_range();
        sel = 1'b0;
        access(1'b0, 32'h0000_0400, 32'd0, 0);
        access(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 0);
        access(1'b0, 32'h0000_0000, 32'd0, 0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        lsu_state = 2'b01; addr_valid = 1'b1; addr = 32'h0000_0020;
        write_mem = 1'b1; write_data_valid = 1'b1; write_data = 32'h0000_1234; read_mem = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (m_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_accept: busy=%b required 1", m_busy);
        end
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_mid_outputs");
        @(posedge clk); #1;
        check_all_zero("reset_mid_no_done");
        rst = 1'b0;
        model_reset();
        access(1'b0, 32'h0000_0020, 32'd0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        access(1'b1, 32'h0000_0030, 32'h0000_5A5A, 0);
        access(1'b0, 32'h0000_0030, 32'd0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          w;
        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom % 2);
            w   = 1'($urandom % 2);
            a   = $urandom & 32'h0000_003F;
            if ($urandom % 8 == 0) a = a | (32'h1 << (10 + ($urandom % 22)));
            access(w, a, $urandom, (w && ($urandom % 4 == 0)) ? int'($urandom % 3) : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0;
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_stale();
        test_wdv_late();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-memory responder serving the load/store unit's memory request interface; the memory side of the LSU handshake.
- Accepts one word request at a time from the LSU, waits a programmable latency, then performs the read or write on an internal word array.
- Returns read data on DCache_data with a one-cycle mem_done pulse.
- Also provides an access-error flag and read/write access counters for debug.

Parameters:
- ADDR_WIDTH, 8, log2 of array depth in 32-bit words (array holds 2**ADDR_WIDTH words).
- LATENCY, 2, cycles from request accept to mem_done; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lsu_state  in  2  LSU state; 2'b01 = issuing request
- read_mem  in  1  load request qualifier
- write_mem  in  1  store request qualifier
- addr  in  32  byte address
- addr_valid  in  1  addr operands resolved
- write_data  in  32  store data, already zero-extended by the LSU
- write_data_valid  in  1  store data resolved
- mem_done  out  1  one-cycle completion pulse
- DCache_data  out  32  read data
- busy  out  1  request in flight
- access_err  out  1  pulses with mem_done when the access was out of range
- rd_count  out  16  completed reads, wraps
- wr_count  out  16  completed writes, wraps

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, all array words 0.
- Reset mid-operation: the transaction is aborted, a pending write is dropped and no mem_done is produced.
- States: IDLE, WAIT, RESP.
- IDLE accept condition: lsu_state==2'b01 & addr_valid & (read_mem | (write_mem & write_data_valid)).
  - A request is accepted only when lsu_state==2'b01. This blocks re-acceptance of the stale request the LSU still presents in states 10/11/00.
  - On accept, latch the op, word index addr[ADDR_WIDTH+1:2], write_data and the range flag.
  - Range flag: out of range if any addr[31:ADDR_WIDTH+2] bit is set.
  - Load counter cnt = LATENCY-1; go to WAIT, or go directly to RESP if LATENCY==1.
- If read_mem and write_mem are both high, the write wins (read ignored).
- addr[1:0] is ignored; accesses are whole-word only.
- WAIT: decrement cnt; when cnt==1, go to RESP at the next edge.
- RESP (exactly one cycle):
  - mem_done=1.
  - access_err = range flag.
  - Return to IDLE next edge; no new accept is allowed in the RESP cycle.
- Latency: mem_done is high in the LATENCY-th cycle after the accept edge.
  - With LATENCY=1, mem_done is high in the cycle right after the accept edge, while the LSU is in state 10.
- Read:
  - DCache_data is registered at the edge entering RESP, from array[index], or 0 if out of range.
  - DCache_data holds its value until the next read enters RESP. Writes never change DCache_data.
- Write:
  - array[index] <= write_data at the edge entering RESP.
  - An out-of-range write is dropped.
- Counters:
  - rd_count or wr_count increments at the edge entering RESP, including errored accesses.
  - Counters wrap 16'hFFFF -> 0.
- busy = (state != IDLE).
- Outstanding requests: only one is ever outstanding; input changes while busy are ignored.
- Read-after-write: a read accepted after a write's RESP sees the written data.

Test Plan:
- LATENCY=2: reset; store addr=0x10, data=0x0000_00AB (lsu_state=01, write_mem, both valids) -> mem_done in 2nd cycle after accept; wr_count=1; DCache_data stays 0.
- Then load from addr=0x10 -> DCache_data=0x0000_00AB in the same cycle as mem_done; rd_count=1; access_err=0.
- Hold read_mem, addr_valid and an in-range addr with lsu_state cycling 10->11->00 after a completed load -> no second accept, busy=0, exactly one mem_done.
- write_mem=1 with write_data_valid=0 for 3 cycles, then 1 -> accept only on the cycle write_data_valid rises; mem_done exactly LATENCY cycles later.
- Load from addr=0x0000_0400 (out of range, ADDR_WIDTH=8) -> mem_done=1, access_err=1, DCache_data=0. Store to the same addr -> array unchanged (verify by reading addr 0x0 = 0).
- Assert rst during WAIT of a store to addr=0x20, data=0x1234 -> no mem_done; all outputs 0; a subsequent read of 0x20 returns 0. With LATENCY=1, the back-to-back store/load pair completes in 1 cycle each.
